nice_gemm_cmd_queue: RTL

//  NICE-port command front-end for the GEMM accelerator, parametrised successor of the fixed NICE_GEMM_top decoder.

---
 rtl/nice_gemm_cmd_queue_pkg.sv | 18 +
 rtl/nice_gemm_cmd_queue_job_fifo.sv | 60 ++++++
 rtl/nice_gemm_cmd_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/nice_gemm_cmd_queue_pkg.sv
// Shared opcodes, funct3 codes and FSM encoding for the GEMM NICE command queue.
package nice_gemm_pkg;

  localparam logic [6:0] OPC_CUSTOM1 = 7'b0101011;
  localparam logic [2:0] F3_CFG      = 3'b011;
  localparam logic [2:0] F3_START    = 3'b010;
  localparam logic [2:0] F3_STATUS   = 3'b110;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_t;

  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/nice_gemm_cmd_queue_job_fifo.sv
// First-word-fall-through register FIFO holding config snapshots for the GEMM engine.
module nice_job_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  // An empty queue presents zeros rather than a stale entry.
  assign pop_data  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/nice_gemm_cmd_queue.sv
// NICE-port command front-end: decodes custom-1 config/START/STATUS instructions,
// keeps the config register file and feeds config snapshots into the job queue.
module nice_gemm_cmd_queue
  import nice_gemm_pkg::*;
#(
  parameter int NUM_PAIRS = 6,
  parameter int START_BIT = 6,
  parameter int JOB_DEPTH = 4,
  parameter int DATA_W    = 32
) (
  input  logic                          nice_clk,
  input  logic                          nice_rst,
  input  logic                          nice_req_valid,
  output logic                          nice_req_ready,
  input  logic [31:0]                   nice_req_instr,
  input  logic [DATA_W-1:0]             nice_req_rs1,
  input  logic [DATA_W-1:0]             nice_req_rs2,
  output logic                          nice_rsp_multicyc_valid,
  input  logic                          nice_rsp_multicyc_ready,
  output logic [31:0]                   nice_rsp_multicyc_dat,
  output logic                          nice_rsp_multicyc_err,
  output logic                          job_valid,
  input  logic                          job_ready,
  output logic [2*NUM_PAIRS*DATA_W-1:0] job_cfg,
  input  logic                          job_done,
  output logic                          busy
);

  localparam int NUM_CFG = 2 * NUM_PAIRS;
  localparam int CFG_W   = NUM_CFG * DATA_W;
  localparam int CW      = $clog2(JOB_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(JOB_DEPTH);
  localparam logic [6:0]    PAIR_MASK = 7'((8'd1 << NUM_PAIRS) - 8'd1);
  localparam logic [6:0]    START_F7  = 7'(8'd1 << START_BIT);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              ready_r;
  logic              ready_nxt_s;
  logic [31:0]       dat_r;
  logic [31:0]       dat_nxt_s;
  logic              err_r;
  logic              err_nxt_s;
  logic [DATA_W-1:0] cfg_r [NUM_CFG];
  logic [7:0]        job_idx_r;
  logic [15:0]       done_cnt_r;

  logic [6:0]        opc_s;
  logic [2:0]        f3_s;
  logic [6:0]        f7_s;
  logic              is_cfg_s;
  logic              is_start_s;
  logic              is_status_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              q_full_s;
  logic              q_empty_s;
  logic [CW-1:0]     q_count_s;
  logic [CW-1:0]     q_count_nxt_s;
  logic [CFG_W-1:0]  snap_s;
  logic              unused_instr_s;

  assign opc_s = nice_req_instr[6:0];
  assign f3_s  = nice_req_instr[14:12];
  assign f7_s  = nice_req_instr[31:25];
  assign unused_instr_s = ^{nice_req_instr[24:15], nice_req_instr[11:7], q_full_s};

  assign is_cfg_s    = (opc_s == OPC_CUSTOM1) && (f3_s == F3_CFG) && is_onehot7(f7_s)
                       && ((f7_s & ~PAIR_MASK) == 7'd0);
  assign is_start_s  = (opc_s == OPC_CUSTOM1) && (f3_s == F3_START) && (f7_s == START_F7);
  assign is_status_s = (opc_s == OPC_CUSTOM1) && (f3_s == F3_STATUS) && (f7_s == 7'd0);

  // ready_r is only ever set in IDLE with room in the queue, so it alone qualifies accept.
  assign accept_s      = nice_req_valid & ready_r;
  assign push_s        = accept_s & is_start_s;
  assign pop_s         = job_ready & ~q_empty_s;
  assign q_count_nxt_s = q_count_s + CW'(push_s) - CW'(pop_s);

  always_comb begin
    snap_s = {CFG_W{1'b0}};
    for (int i = 0; i < NUM_CFG; i++) begin
      snap_s[i*DATA_W +: DATA_W] = cfg_r[i];
    end
  end

  always_comb begin
    dat_nxt_s = 32'd0;
    err_nxt_s = 1'b0;
    if (is_cfg_s) begin
      dat_nxt_s = 32'd0;
    end else if (is_start_s) begin
      dat_nxt_s = {24'd0, job_idx_r};
    end else if (is_status_s) begin
      dat_nxt_s = {done_cnt_r, 5'd0, 8'(q_count_s), ~q_empty_s, 2'd0};
    end else begin
      err_nxt_s = 1'b1;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RSP;
        else          state_nxt_s = IDLE;
      end
      RSP: begin
        if (nice_rsp_multicyc_ready) state_nxt_s = IDLE;
        else                         state_nxt_s = RSP;
      end
      default: state_nxt_s = IDLE;
    endcase
    ready_nxt_s = (state_nxt_s == IDLE) && (q_count_nxt_s != DEPTH_C);
  end

  always_ff @(posedge nice_clk or posedge nice_rst) begin
    if (nice_rst) begin
      state_r    <= IDLE;
      ready_r    <= 1'b0;
      dat_r      <= 32'd0;
      err_r      <= 1'b0;
      job_idx_r  <= 8'd0;
      done_cnt_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= ready_nxt_s;
      if (accept_s) begin
        dat_r <= dat_nxt_s;
        err_r <= err_nxt_s;
      end
      if (push_s) begin
        job_idx_r <= job_idx_r + 8'd1;
      end
      if (job_done && (done_cnt_r != 16'hFFFF)) begin
        done_cnt_r <= done_cnt_r + 16'd1;
      end
    end
  end

  always_ff @(posedge nice_clk or posedge nice_rst) begin
    if (nice_rst) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_PAIRS; k++) begin
        if (accept_s && is_cfg_s && f7_s[k]) begin
          cfg_r[2*k]   <= nice_req_rs1;
          cfg_r[2*k+1] <= nice_req_rs2;
        end
      end
    end
  end

  nice_job_fifo #(
    .WIDTH (CFG_W),
    .DEPTH (JOB_DEPTH)
  ) u_job_fifo (
    .clk       (nice_clk),
    .rst       (nice_rst),
    .push      (push_s),
    .push_data (snap_s),
    .pop       (pop_s),
    .pop_data  (job_cfg),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .count     (q_count_s)
  );

  assign nice_req_ready          = ready_r;
  assign nice_rsp_multicyc_valid = (state_r == RSP);
  assign nice_rsp_multicyc_dat   = dat_r;
  assign nice_rsp_multicyc_err   = err_r;
  assign job_valid               = ~q_empty_s;
  assign busy                    = ~q_empty_s;

endmodule
